seq_divider16: RTL



---
 rtl/seq_divider16_if.sv | 35 +++
 rtl/seq_divider16.sv | 115 +++++++++++
 2 files changed

// File: rtl/seq_divider16_if.sv
// rtl/seq_divider16_if.sv - start/done handshake and operand/result bundle for seq_divider16
//
// Signals:
//   start        request a division (sampled by the divider in IDLE or DONE)
//   dividend     unsigned numerator, sampled with start
//   divisor      unsigned denominator, sampled with start
//   busy         division in progress
//   done         one-cycle pulse when results become valid
//   quotient     result quotient, held until the next accepted start completes
//   remainder    result remainder, held likewise
//   div_by_zero  set with done when the divisor was zero
// Modports: master drives requests and reads results, slave is the divider.

interface seq_divider16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider16.sv
// rtl/seq_divider16.sv - iterative restoring unsigned divider, one quotient bit per clock
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   seq_divider16_if slave modport (start/dividend/divisor in,
//         busy/done/quotient/remainder/div_by_zero out, all outputs registered)

module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    seq_divider16_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    // Partial remainder is always < D after a step, so WIDTH bits hold it;
    // the extra bit only exists in the shifted/trial values below.
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    count;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: shift {R,Q} left, try subtracting D, keep the
    // difference only if it did not go negative.
    always_comb begin
        r_shift = {r_reg, q_reg[WIDTH-1]};
        trial   = r_shift - {1'b0, d_reg};
        r_next  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next  = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE lasts one cycle; a start here behaves as in IDLE.
                    state  <= IDLE;
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            q_reg  <= bus.dividend;
                            d_reg  <= bus.divisor;
                            r_reg  <= '0;
                            count  <= CW'(WIDTH);
                            busy_r <= 1'b1;
                            state  <= RUN;
                        end else begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        // Results are published only together with done.
                        quotient_r  <= q_next;
                        remainder_r <= r_next;
                        dbz_r       <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule
